// File: rtl/demux_rr_dispatcher.sv
// One-entry holding register that steers each accepted item to one of four channels,
// picked round-robin over enabled channels or taken directly from the item's in_dest field.
module demux_rr_dispatcher #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [1:0]        in_dest,
   input  logic              mode,
   input  logic [3:0]        ch_en,
   output logic [3:0]        out_valid,
   input  logic [3:0]        out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        cur_dest,
   output logic [7:0]        drop_cnt
);

   // state   | meaning
   // S_EMPTY | holding register invalid, nothing offered downstream
   // S_FULL  | holding register valid, offered on channel r_cur_dest
   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [1:0]        r_rr_ptr;
   logic [1:0]        r_cur_dest;
   logic [DATA_W-1:0] r_out_data;
   logic [7:0]        r_drop_cnt;

   logic              w_fire_out;
   logic              w_fire_in;
   logic              w_capture;
   logic              w_drop;
   logic              w_dir_ok;
   logic [7:0]        w_en_dbl;
   logic [3:0]        w_en_rot;
   logic [1:0]        w_rr_off;
   logic [1:0]        w_rr_pick;

   // Rotate the enable mask so bit k is the channel k steps past r_rr_ptr.
   assign w_en_dbl  = {ch_en, ch_en};
   assign w_en_rot  = w_en_dbl[r_rr_ptr +: 4];
   assign w_rr_pick = r_rr_ptr + w_rr_off;
   assign w_dir_ok  = ch_en[in_dest];

   always_comb begin
      w_rr_off = 2'd3;
      if (w_en_rot[0])      w_rr_off = 2'd0;
      else if (w_en_rot[1]) w_rr_off = 2'd1;
      else if (w_en_rot[2]) w_rr_off = 2'd2;
   end

   assign w_fire_out = (r_state == S_FULL) && out_ready[r_cur_dest];
   assign w_fire_in  = in_valid && in_ready;
   assign w_capture  = w_fire_in && (!mode || w_dir_ok);
   assign w_drop     = w_fire_in && mode && !w_dir_ok;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_EMPTY;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 4'b0000;
      if (!rst && ((r_state == S_EMPTY) || w_fire_out) && (mode || (|ch_en)))
         in_ready = 1'b1;
      case (r_state)
         S_EMPTY: begin
            if (w_capture) w_state_nxt = S_FULL;
         end
         S_FULL: begin
            out_valid = 4'b0001 << r_cur_dest;
            if (w_capture)       w_state_nxt = S_FULL;
            else if (w_fire_out) w_state_nxt = S_EMPTY;
         end
         default: w_state_nxt = S_EMPTY;
      endcase
   end

   // A held item's destination is frozen; only a capture reloads data and destination.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr   <= 2'd0;
         r_cur_dest <= 2'd0;
         r_out_data <= '0;
         r_drop_cnt <= 8'd0;
      end else begin
         if (w_capture) begin
            r_out_data <= in_data;
            if (mode) begin
               r_cur_dest <= in_dest;
            end else begin
               r_cur_dest <= w_rr_pick;
               r_rr_ptr   <= w_rr_pick + 2'd1;
            end
         end
         if (w_drop && (r_drop_cnt != 8'hFF))
            r_drop_cnt <= r_drop_cnt + 8'd1;
      end
   end

   assign out_data = r_out_data;
   assign cur_dest = r_cur_dest;
   assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Bench for demux_rr_dispatcher: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the dispatch rules.
module tb_demux_rr_dispatcher;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [1:0] in_dest;
   logic       mode;
   logic [3:0] ch_en;
   logic [3:0] out_valid;
   logic [3:0] out_ready;
   logic [7:0] out_data;
   logic [1:0] cur_dest;
   logic [7:0] drop_cnt;

   int n_checks = 0;
   int n_fails  = 0;

   demux_rr_dispatcher #(.DATA_W(8)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_dest   (in_dest),
      .mode      (mode),
      .ch_en     (ch_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .cur_dest  (cur_dest),
      .drop_cnt  (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] data;
      logic [1:0] dest;
   } item_t;

   item_t m_q[$];
   int    m_ptr      = 0;
   int    m_drops    = 0;
   int    m_last_dat = 0;
   int    m_last_dst = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // One cycle: drive inputs, check combinational and registered outputs, clock, update model.
   task automatic step(input logic r, input logic v, input logic [7:0] d, input logic [1:0] dst,
                       input logic md, input logic [3:0] en, input logic [3:0] ordy);
      bit       full;
      bit       fire_out;
      bit       irdy;
      int       pick;
      logic [3:0] exp_ov;
      rst = r; in_valid = v; in_data = d; in_dest = dst; mode = md; ch_en = en; out_ready = ordy;
      #2;
      full     = (m_q.size() != 0);
      exp_ov   = full ? (4'd1 << m_q[0].dest) : 4'd0;
      fire_out = full && ordy[m_q[0].dest];
      irdy     = !r && (!full || fire_out) && (md || (en != 4'd0));
      chk("in_ready",  {31'd0, in_ready}, {31'd0, irdy});
      chk("out_valid", {28'd0, out_valid}, {28'd0, exp_ov});
      chk("out_data",  {24'd0, out_data}, m_last_dat);
      chk("cur_dest",  {30'd0, cur_dest}, m_last_dst);
      chk("drop_cnt",  {24'd0, drop_cnt}, m_drops);
      @(posedge clk);
      if (r) begin
         m_q.delete();
         m_ptr = 0; m_drops = 0; m_last_dat = 0; m_last_dst = 0;
      end else begin
         if (fire_out) void'(m_q.pop_front());
         if (v && irdy) begin
            if (md) begin
               if (en[dst]) begin
                  m_q.push_back('{data: d, dest: dst});
                  m_last_dat = d; m_last_dst = dst;
               end else if (m_drops < 255) begin
                  m_drops++;
               end
            end else begin
               pick = -1;
               for (int k = 0; k < 4; k++)
                  if (pick < 0 && en[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
               m_q.push_back('{data: d, dest: pick[1:0]});
               m_last_dat = d; m_last_dst = pick;
               m_ptr = (pick + 1) % 4;
            end
         end
      end
      #1;
   endtask

   task automatic do_reset();
      step(1, 0, 8'h00, 2'd0, 0, 4'hF, 4'hF);
      step(1, 0, 8'h00, 2'd0, 0, 4'hF, 4'hF);
   endtask

   logic       r_md;
   logic [3:0] r_en;

   initial begin
      rst = 1'b1; in_valid = 0; in_data = 0; in_dest = 0; mode = 0; ch_en = 0; out_ready = 0;
      @(posedge clk); #1;
      do_reset();
      chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
      chk("rst_drop_cnt",  {24'd0, drop_cnt}, 32'd0);

      // Round-robin, all enabled, back-to-back
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 8'hA1 + 8'(i), 2'd0, 0, 4'hF, 4'hF);
         chk("rr_all_dest", {30'd0, cur_dest}, i % 4);
      end
      step(0, 0, 8'h00, 2'd0, 0, 4'hF, 4'hF);

      // Sparse enable mask, then mask cleared
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 8'h10 + 8'(i), 2'd0, 0, 4'b1010, 4'hF);
         chk("rr_1010_dest", {30'd0, cur_dest}, (i % 2 == 0) ? 1 : 3);
      end
      step(0, 1, 8'h20, 2'd0, 0, 4'b0000, 4'hF);
      chk("rr_off_drained", {28'd0, out_valid}, 32'd0);
      step(0, 1, 8'h21, 2'd0, 0, 4'b0000, 4'hF);

      // Backpressure on channel 2, then pass-through
      do_reset();
      step(0, 1, 8'h01, 2'd0, 0, 4'hF, 4'hF);
      step(0, 1, 8'h02, 2'd0, 0, 4'hF, 4'hF);
      step(0, 1, 8'h5C, 2'd0, 0, 4'hF, 4'hF);
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 8'h77, 2'd0, 0, 4'hF, 4'b1011);
         chk("bp_out_valid", {28'd0, out_valid}, 32'h4);
         chk("bp_out_data",  {24'd0, out_data}, 32'h5C);
      end
      step(0, 1, 8'h77, 2'd0, 0, 4'hF, 4'hF);
      chk("bp_pass_data", {24'd0, out_data}, 32'h77);
      chk("bp_pass_dest", {30'd0, cur_dest}, 32'd3);
      step(0, 0, 8'h00, 2'd0, 0, 4'hF, 4'hF);

      // Directed mode with a disabled destination
      do_reset();
      step(0, 1, 8'h33, 2'd3, 1, 4'b1011, 4'h0);
      chk("dir_ov3", {28'd0, out_valid}, 32'h8);
      step(0, 1, 8'h44, 2'd2, 1, 4'b1011, 4'hF);
      chk("dir_drop1", {24'd0, drop_cnt}, 32'd1);
      chk("dir_drop_empty", {28'd0, out_valid}, 32'd0);
      for (int i = 0; i < 300; i++) step(0, 1, 8'(i), 2'd2, 1, 4'b1011, 4'hF);
      chk("dir_drop_sat", {24'd0, drop_cnt}, 32'd255);

      // Mode switch keeps the round-robin pointer
      do_reset();
      step(0, 1, 8'h61, 2'd0, 0, 4'hF, 4'hF);
      step(0, 1, 8'h62, 2'd0, 0, 4'hF, 4'hF);
      for (int i = 0; i < 3; i++) step(0, 1, 8'h70 + 8'(i), 2'd0, 1, 4'hF, 4'hF);
      step(0, 1, 8'h80, 2'd0, 0, 4'hF, 4'hF);
      chk("mode_sw_dest", {30'd0, cur_dest}, 32'd2);
      step(0, 0, 8'h00, 2'd0, 0, 4'hF, 4'hF);

      // Reset while holding an undelivered item
      step(0, 1, 8'h90, 2'd0, 0, 4'hF, 4'h0);
      step(0, 1, 8'h91, 2'd0, 0, 4'hF, 4'h0);
      step(1, 1, 8'h92, 2'd0, 0, 4'hF, 4'h0);
      chk("rst_full_ov", {28'd0, out_valid}, 32'd0);
      chk("rst_full_drop", {24'd0, drop_cnt}, 32'd0);
      step(0, 1, 8'h93, 2'd0, 0, 4'hF, 4'hF);
      chk("rst_first_rr", {30'd0, cur_dest}, 32'd0);

      // Random traffic
      r_md = 0; r_en = 4'hF;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0) r_md = 1'($urandom);
         if ($urandom_range(0, 9) == 0) r_en = 4'($urandom);
         step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), 8'($urandom),
              2'($urandom), r_md, r_en, 4'($urandom | $urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/demux_rr_dispatcher.md
# demux_rr_dispatcher

Registered dispatcher that accepts a stream of data items on a single valid/ready input and delivers each item to exactly one of four output channels, acting as the sequencing controller for the team's 1-to-4 demultiplexer datapath. Destination is chosen either by rotating round-robin over the enabled channels or directly from a per-item destination field. A one-entry holding register decouples input from output while allowing one item per cycle when the destination is ready.

## Interface
- DATA_W, 8, width of the data item

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input item present
- in_ready  output  1  dispatcher can accept an item this cycle
- in_data  input  DATA_W  input item
- in_dest  input  2  destination channel, used only in directed mode
- mode  input  1  0 = round-robin, 1 = directed
- ch_en  input  4  per-channel enable mask
- out_valid  output  4  one-hot; bit d high = item held for channel d
- out_ready  input  4  per-channel accept
- out_data  output  DATA_W  held item, shared by all channels
- cur_dest  output  2  destination of the held item
- drop_cnt  output  8  directed-mode items dropped for a disabled destination, saturating

## Operation
- Two states: EMPTY (holding register invalid) and FULL (holding register valid).
- fire_out = FULL && out_ready[cur_dest]. fire_in = in_valid && in_ready.
- in_ready = !rst && (EMPTY || fire_out) && (mode || |ch_en). It is combinational from out_ready; with ch_en = 0 in round-robin mode, in_ready = 0.
- out_valid[d] = FULL && (cur_dest == d). All other bits are 0; out_valid is never more than one-hot.
- mode, ch_en and in_dest are sampled only on a fire_in edge. A held item's destination never changes and its out_valid stays high until delivered, even if ch_en later clears that channel.
- Round-robin pick: the first d in the order rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3 (mod 4) with ch_en[d] = 1. On capture: cur_dest <= pick, rr_ptr <= pick + 1 (mod 4, 3 wraps to 0).
- Directed mode: if ch_en[in_dest] = 1, capture with cur_dest <= in_dest; rr_ptr is unchanged. If ch_en[in_dest] = 0, the item is accepted (fire_in), discarded, drop_cnt increments (holds at 255), and the state is unchanged by the capture.
- Transitions:
  - EMPTY, captured: goes to FULL.
  - FULL, fire_out without capture: goes to EMPTY.
  - FULL, fire_out and capture on the same edge: stays FULL with the new item (pass-through).
  - FULL, fire_out and a dropped item on the same edge: goes to EMPTY.
- out_data and cur_dest load only on capture; otherwise they hold their value.

## Timing
- Reset (rst high at a clk edge) sets: state EMPTY, rr_ptr 0, cur_dest 0, out_data 0, drop_cnt 0.
  - Therefore out_valid = 0 after reset.
  - in_ready = 0 while rst is high.
- Reset mid-operation discards the held item with no delivery.
- Latency: an item captured at edge N shows out_valid from after edge N. The earliest delivery is edge N+1.
- Throughput: one item per cycle while the current destination's out_ready stays high.
- Accepted items are delivered in acceptance order, excluding drops.
- out_valid and out_data are stable while out_ready is low, per the valid/ready rule.

## Test plan
- Reset, round-robin, ch_en = 1111, out_ready = 1111, items 0xA1..0xA5 back-to-back -> deliveries on channels 0, 1, 2, 3, 0, one per cycle, each 1 cycle after capture; in_ready stays 1.
- ch_en = 1010, round-robin, rr_ptr = 0, four items -> channels 1, 3, 1, 3. Then ch_en = 0000 -> in_ready = 0 and out_valid drains to 0.
- Backpressure: item 0x5C held for channel 2 with out_ready[2] = 0 for 5 cycles -> out_valid = 0100 and out_data = 0x5C stable, in_ready = 0. Raising out_ready[2] with in_valid high -> delivery and a new capture on the same edge.
- Directed, ch_en = 1011: in_dest = 3 -> delivered on channel 3. in_dest = 2 -> accepted and dropped, drop_cnt = 1, out_valid = 0000. Then 300 drops -> drop_cnt = 255.
- Mode switch: round-robin leaves rr_ptr = 2, then 3 directed items to channel 0, then back to round-robin -> next round-robin item goes to channel 2.
- Assert rst while FULL with out_ready = 0 -> next cycle out_valid = 0000, drop_cnt = 0. The first round-robin item after release goes to channel 0.
